// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: redirect-select encodings, fetch FSM states,
// default reset PC and a word-alignment helper.
package cpu_defs_pkg;

    // Redirect select driven by the hazard/branch logic.
    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_J   = 2'b10;
    localparam logic [1:0] PCSRC_JR  = 2'b11;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_READY   = 2'd2,
        ST_DISCARD = 2'd3
    } if_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Every PC loaded into the fetch unit is forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC select: sequential PC+4 or one of the branch/jump/jr targets,
// always word aligned. Purely combinational.
module pc_next_mux
    import cpu_defs_pkg::*;
(
    input  logic [1:0]  pcsrc_i,
    input  logic [31:0] branch_target_i,
    input  logic [25:0] jump_target_i,
    input  logic [31:0] id_pcadd4_i,
    input  logic [31:0] jr_target_i,
    input  logic [31:0] if_pc_i,
    output logic        redirect_o,
    output logic [31:0] next_pc_o
);

    logic [31:0] raw_target;

    // Only the region bits of the jumping instruction's PC+4 form the jump target.
    logic unused_pcadd4_lo;
    assign unused_pcadd4_lo = ^id_pcadd4_i[27:0];

    assign redirect_o = (pcsrc_i != PCSRC_SEQ);

    // Select the raw target, then align it.
    always_comb begin
        raw_target = if_pc_i + 32'd4;
        case (pcsrc_i)
            PCSRC_BR: raw_target = branch_target_i;
            PCSRC_J:  raw_target = {id_pcadd4_i[31:28], jump_target_i, 2'b00};
            PCSRC_JR: raw_target = jr_target_i;
            default:  raw_target = if_pc_i + 32'd4;
        endcase
    end

    assign next_pc_o = align_word(raw_target);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a
// req/ack handshake and presents the fetched word plus PC+4 to IF/ID.
//
// Handshake: once IMem_Req rises, IMem_Addr stays stable and Req stays high
// until the cycle IMem_Ack is seen; data is taken only in the Ack cycle.
// The one exception is READY with PCWre=1, where Req/Addr are a same-cycle
// request for PC+4 that falls back to FETCH (holding that address) if not
// acked immediately. A reset abandons any outstanding request at once.
module instruction_fetch_unit
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [25:0] JumpTarget,
    input  logic [31:0] ID_PCadd4,
    input  logic [31:0] JrTarget,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_RData,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PCadd4,
    output logic [31:0] IF_Instruction,
    output logic        IF_Valid,
    output logic [1:0]  DbgState
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] hold_addr_q, hold_addr_d;   // squashed address kept on the bus in DISCARD

    logic        redirect;
    logic [31:0] next_pc;

    pc_next_mux u_pc_next_mux (
        .pcsrc_i         (PCSrc),
        .branch_target_i (BranchTarget),
        .jump_target_i   (JumpTarget),
        .id_pcadd4_i     (ID_PCadd4),
        .jr_target_i     (JrTarget),
        .if_pc_i         (pc_q),
        .redirect_o      (redirect),
        .next_pc_o       (next_pc)
    );

    // State, PC, fetched word and squashed-address registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= 32'h0;
            hold_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            hold_addr_q <= hold_addr_d;
        end
    end

    // Next-state and memory-request decode; redirect beats advance beats hold.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        hold_addr_d = hold_addr_q;
        IMem_Req    = 1'b0;
        IMem_Addr   = pc_q;
        IF_Valid    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                if (redirect) pc_d = next_pc;
            end

            ST_FETCH: begin
                IMem_Req = 1'b1;
                if (redirect) begin
                    pc_d = next_pc;
                    if (!IMem_Ack) begin
                        // Request still in flight: keep its address until acked.
                        hold_addr_d = pc_q;
                        state_d     = ST_DISCARD;
                    end
                end else if (IMem_Ack) begin
                    instr_d = IMem_RData;
                    state_d = ST_READY;
                end
            end

            ST_DISCARD: begin
                IMem_Req  = 1'b1;
                IMem_Addr = hold_addr_q;
                if (redirect) pc_d = next_pc;
                if (IMem_Ack) state_d = ST_FETCH;
            end

            ST_READY: begin
                IF_Valid = 1'b1;
                if (redirect) begin
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
                end else if (PCWre) begin
                    // next_pc is PC+4 here since no redirect is selected.
                    IMem_Req  = 1'b1;
                    IMem_Addr = next_pc;
                    pc_d      = next_pc;
                    if (IMem_Ack) instr_d = IMem_RData;
                    else          state_d = ST_FETCH;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign IF_PC          = pc_q;
    assign IF_PCadd4      = pc_q + 32'd4;
    assign IF_Instruction = instr_q;
    assign DbgState       = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a wait-state memory model
// returning addr ^ 32'hA5A5_0000.
module tb_instruction_fetch_unit;
    import cpu_defs_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic [31:0] BranchTarget;
    logic [25:0] JumpTarget;
    logic [31:0] ID_PCadd4;
    logic [31:0] JrTarget;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ack;
    logic [31:0] IMem_RData;
    logic [31:0] IF_PC;
    logic [31:0] IF_PCadd4;
    logic [31:0] IF_Instruction;
    logic        IF_Valid;
    logic [1:0]  DbgState;

    int n_cmp  = 0;
    int n_fail = 0;

    int wait_n = 0;
    int wait_cnt;

    // ---- clock / reset ----
    always #5 Clk = ~Clk;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .PCWre          (PCWre),
        .PCSrc          (PCSrc),
        .BranchTarget   (BranchTarget),
        .JumpTarget     (JumpTarget),
        .ID_PCadd4      (ID_PCadd4),
        .JrTarget       (JrTarget),
        .IMem_Req       (IMem_Req),
        .IMem_Addr      (IMem_Addr),
        .IMem_Ack       (IMem_Ack),
        .IMem_RData     (IMem_RData),
        .IF_PC          (IF_PC),
        .IF_PCadd4      (IF_PCadd4),
        .IF_Instruction (IF_Instruction),
        .IF_Valid       (IF_Valid),
        .DbgState       (DbgState)
    );

    // ---- memory model: acks after wait_n cycles of held request ----
    always @(posedge Clk or negedge Reset) begin
        if (!Reset)                     wait_cnt <= 0;
        else if (IMem_Req && !IMem_Ack) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
    end
    assign IMem_Ack   = IMem_Req && (wait_cnt >= wait_n);
    assign IMem_RData = IMem_Addr ^ 32'hA5A5_0000;

    // ---- driver / checker tasks ----
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b0; PCWre = 1'b1; PCSrc = PCSRC_SEQ;
        BranchTarget = 32'h0; JumpTarget = 26'h0; ID_PCadd4 = 32'h0; JrTarget = 32'h0;
        wait_n = 0;

        // Reset values
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_pc",     IF_PC, 32'h0);
        chk("rst_pcadd4", IF_PCadd4, 32'h4);
        chk("rst_instr",  IF_Instruction, 32'h0);
        chk("rst_valid",  {31'h0, IF_Valid}, 32'h0);
        chk("rst_req",    {31'h0, IMem_Req}, 32'h0);
        chk("rst_addr",   IMem_Addr, 32'h0);
        chk("rst_state",  {30'h0, DbgState}, {30'h0, ST_IDLE});

        // Zero-wait sequential fetch
        @(negedge Clk) Reset = 1'b1;
        tick(); // edge 1: FETCH at 0
        chk("e1_addr",  IMem_Addr, 32'h0);
        chk("e1_req",   {31'h0, IMem_Req}, 32'h1);
        chk("e1_valid", {31'h0, IF_Valid}, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick(); // edges 2..4
            chk("seq_valid",  {31'h0, IF_Valid}, 32'h1);
            chk("seq_addr",   IMem_Addr, 32'(4 * i));
            chk("seq_pc",     IF_PC, 32'(4 * (i - 1)));
            chk("seq_pcadd4", IF_PCadd4, 32'(4 * i));
            chk("seq_instr",  IF_Instruction, 32'(4 * (i - 1)) ^ 32'hA5A5_0000);
        end
        tick(); // edge 5: pc=C
        tick(); // edge 6: pc=10
        chk("pre_stall_pc", IF_PC, 32'h10);

        // Stall in READY at 0x10
        PCWre = 1'b0;
        #1;
        chk("stall_req0", {31'h0, IMem_Req}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc",    IF_PC, 32'h10);
            chk("stall_instr", IF_Instruction, 32'hA5A5_0010);
            chk("stall_valid", {31'h0, IF_Valid}, 32'h1);
            chk("stall_req",   {31'h0, IMem_Req}, 32'h0);
        end

        // Branch while READY (PCWre=0), unaligned target
        PCSrc = PCSRC_BR; BranchTarget = 32'h0000_0043;
        tick();
        chk("br_addr",  IMem_Addr, 32'h40);
        chk("br_req",   {31'h0, IMem_Req}, 32'h1);
        chk("br_valid", {31'h0, IF_Valid}, 32'h0);
        PCSrc = PCSRC_SEQ; PCWre = 1'b1;
        tick();
        chk("br_instr", IF_Instruction, 32'hA5A5_0040);
        chk("br_pc",    IF_PC, 32'h40);
        chk("br_vld",   {31'h0, IF_Valid}, 32'h1);

        // 3-wait memory, jump issued in FETCH at 0x8
        PCWre = 1'b0; wait_n = 3;
        PCSrc = PCSRC_BR; BranchTarget = 32'h8;
        tick(); // FETCH at 8
        chk("j_fetch_addr", IMem_Addr, 32'h8);
        PCSrc = PCSRC_J; JumpTarget = 26'h10; ID_PCadd4 = 32'h3000_0004;
        tick(); // -> DISCARD
        PCSrc = PCSRC_SEQ;
        chk("j_state", {30'h0, DbgState}, {30'h0, ST_DISCARD});
        chk("j_pc",    IF_PC, 32'h3000_0040);
        for (int i = 0; i < 3; i++) begin
            chk("disc_addr",  IMem_Addr, 32'h8);
            chk("disc_req",   {31'h0, IMem_Req}, 32'h1);
            chk("disc_valid", {31'h0, IF_Valid}, 32'h0);
            if (i < 2) tick();
        end
        chk("disc_ack", {31'h0, IMem_Ack}, 32'h1);
        tick(); // discard acked -> FETCH at jump target
        chk("j_addr", IMem_Addr, 32'h3000_0040);
        for (int i = 0; i < 3; i++) begin
            chk("j_wait_valid", {31'h0, IF_Valid}, 32'h0);
            tick();
        end
        chk("j_wait_valid", {31'h0, IF_Valid}, 32'h0);
        tick();
        chk("j_valid", {31'h0, IF_Valid}, 32'h1);
        chk("j_instr", IF_Instruction, 32'h95A5_0040);

        // Reset while a request is pending
        PCSrc = PCSRC_BR; BranchTarget = 32'h80;
        tick();
        PCSrc = PCSRC_SEQ;
        tick();
        chk("pend_req", {31'h0, IMem_Req}, 32'h1);
        #2 Reset = 1'b0;
        #1;
        chk("mid_rst_req",   {31'h0, IMem_Req}, 32'h0);
        chk("mid_rst_valid", {31'h0, IF_Valid}, 32'h0);
        chk("mid_rst_pc",    IF_PC, 32'h0);

        // jr to top of memory, then wrap on advance
        wait_n = 0;
        @(negedge Clk) Reset = 1'b1;
        tick(); // FETCH 0
        tick(); // READY 0
        PCSrc = PCSRC_JR; JrTarget = 32'hFFFF_FFFC;
        tick();
        chk("jr_addr", IMem_Addr, 32'hFFFF_FFFC);
        PCSrc = PCSRC_SEQ; PCWre = 1'b1;
        tick();
        chk("jr_pc",       IF_PC, 32'hFFFF_FFFC);
        chk("wrap_addr",   IMem_Addr, 32'h0);
        chk("wrap_pcadd4", IF_PCadd4, 32'h0);
        tick();
        chk("wrap_pc",    IF_PC, 32'h0);
        chk("wrap_instr", IF_Instruction, 32'hA5A5_0000);

        // ---- report ----
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
